// File: rtl/joy_pkg.sv
// Shared types and constants for the JAMMA joystick scanner.
// Optional debounce is enabled by defining JOY_DEBOUNCE_EN.
package joy_pkg;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } scan_state_e;

    localparam int unsigned JOY_START = 7;
    localparam int unsigned JOY_FIRE2 = 6;
    localparam logic [7:0]  JOY_IDLE  = 8'hFF;

endpackage

// File: rtl/joy_debounce.sv
// Per-bit debouncer clocked by a scan tick; with JOY_DEBOUNCE_EN defined a bit changes
// only after DEBOUNCE_SCANS consecutive disagreeing scans, otherwise it follows the raw scan.
module joy_debounce #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] deb_next_o
);

    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_scans
        $error("joy_debounce: DEBOUNCE_SCANS out of range 1..15");
    end

    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_d;

`ifdef JOY_DEBOUNCE_EN
    logic [WIDTH-1:0][3:0] cnt_q;
    logic [WIDTH-1:0][3:0] cnt_d;

    // Counter never exceeds DEBOUNCE_SCANS-1: reaching it flips the bit and clears.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (tick_i) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (raw_i[i] != deb_q[i]) begin
                    if (cnt_q[i] >= 4'(DEBOUNCE_SCANS - 1)) begin
                        deb_d[i] = raw_i[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            deb_q <= '1;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end
`else
    assign deb_d = tick_i ? raw_i : deb_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            deb_q <= '1;
        end else begin
            deb_q <= deb_d;
        end
    end
`endif

    assign deb_next_o = deb_d;

endmodule

// File: rtl/jamma_joy_scan.sv
// Two-phase JAMMA joystick bus scanner with keyboard merge and scan-tick debouncing.
// Define JOY_DEBOUNCE_EN to enable multi-scan debounce; otherwise outputs follow the last scan.
module jamma_joy_scan
    import joy_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] JJOY,
    input  logic [1:0] JCOIN,
    input  logic [5:0] KBD_JOY,
    output logic       JSELECT,
    output logic [7:0] JOY1,
    output logic [7:0] JOY2,
    output logic [1:0] COIN,
    output logic       SCAN_DONE
);

    if (SETTLE_CYCLES < 4 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("jamma_joy_scan: SETTLE_CYCLES out of range 4..255");
    end

    logic [7:0]  jjoy_s1_q, jjoy_s2_q;
    logic [1:0]  jcoin_s1_q, jcoin_s2_q;
    scan_state_e state_q;
    logic [7:0]  cnt_q;
    logic        jsel_q;
    logic [7:0]  raw_a_q, raw_b_q;
    logic [1:0]  raw_coin_q;
    logic        scan_done_q;
    logic [7:0]  joy1_q, joy2_q;
    logic [1:0]  coin_q;
    logic [7:0]  deb_a_d, deb_b_d;
    logic [1:0]  deb_c_d;
    logic        phase_end;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            jjoy_s1_q  <= JOY_IDLE;
            jjoy_s2_q  <= JOY_IDLE;
            jcoin_s1_q <= '1;
            jcoin_s2_q <= '1;
        end else begin
            jjoy_s1_q  <= JJOY;
            jjoy_s2_q  <= jjoy_s1_q;
            jcoin_s1_q <= JCOIN;
            jcoin_s2_q <= jcoin_s1_q;
        end
    end

    assign phase_end = (cnt_q == 8'(SETTLE_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= SEL_A;
            cnt_q       <= '0;
            jsel_q      <= 1'b0;
            raw_a_q     <= JOY_IDLE;
            raw_b_q     <= JOY_IDLE;
            raw_coin_q  <= '1;
            scan_done_q <= 1'b0;
            joy1_q      <= JOY_IDLE;
            joy2_q      <= JOY_IDLE;
            coin_q      <= '1;
        end else begin
            scan_done_q <= 1'b0;
            if (phase_end) begin
                cnt_q <= '0;
                if (state_q == SEL_A) begin
                    raw_a_q <= jjoy_s2_q;
                    state_q <= SEL_B;
                    jsel_q  <= 1'b1;
                end else begin
                    raw_b_q     <= jjoy_s2_q;
                    raw_coin_q  <= jcoin_s2_q;
                    state_q     <= SEL_A;
                    jsel_q      <= 1'b0;
                    scan_done_q <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
            // Outputs only move at the end of the SCAN_DONE cycle, so no mid-scan glitches.
            if (scan_done_q) begin
                joy1_q <= {deb_a_d[JOY_START:JOY_FIRE2], deb_a_d[JOY_FIRE2-1:0] & KBD_JOY};
                joy2_q <= deb_b_d;
                coin_q <= deb_c_d;
            end
        end
    end

    joy_debounce #(.WIDTH(8), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb_a (
        .clk_i(CLK), .rst_n_i(RESET_N), .tick_i(scan_done_q),
        .raw_i(raw_a_q), .deb_next_o(deb_a_d)
    );

    joy_debounce #(.WIDTH(8), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb_b (
        .clk_i(CLK), .rst_n_i(RESET_N), .tick_i(scan_done_q),
        .raw_i(raw_b_q), .deb_next_o(deb_b_d)
    );

    joy_debounce #(.WIDTH(2), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb_c (
        .clk_i(CLK), .rst_n_i(RESET_N), .tick_i(scan_done_q),
        .raw_i(raw_coin_q), .deb_next_o(deb_c_d)
    );

    assign JSELECT   = jsel_q;
    assign JOY1      = joy1_q;
    assign JOY2      = joy2_q;
    assign COIN      = coin_q;
    assign SCAN_DONE = scan_done_q;

endmodule

// File: tb/tb_jamma_joy_scan.sv
// Self-checking bench for jamma_joy_scan: cycle-level reference model plus directed checks.
module tb_jamma_joy_scan;

    localparam int S   = 8;
    localparam int DEB = 3;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] JJOY;
    logic [1:0] JCOIN;
    logic [5:0] KBD_JOY;
    logic       JSELECT;
    logic [7:0] JOY1, JOY2;
    logic [1:0] COIN;
    logic       SCAN_DONE;

    logic [7:0] p1, p2;
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    jamma_joy_scan #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(DEB)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .JJOY(JJOY), .JCOIN(JCOIN), .KBD_JOY(KBD_JOY),
        .JSELECT(JSELECT), .JOY1(JOY1), .JOY2(JOY2), .COIN(COIN), .SCAN_DONE(SCAN_DONE)
    );

    always #5 CLK = ~CLK;

    // Board-level player mux: the selected player's switches appear on the shared bus.
    always @(*) JJOY = JSELECT ? p2 : p1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         e;
    logic [7:0] jj_d1, jj_d2, sj;
    logic [1:0] jc_d1, jc_d2, sc;
    logic [7:0] mra, mrb;
    logic [1:0] mrc;
    logic [7:0] mdeb_a, mdeb_b, mdeb_c;
    logic       m_jsel, m_done;
    logic [7:0] m_joy1, m_joy2;
    logic [1:0] m_coin;

`ifdef JOY_DEBOUNCE_EN
    logic [7:0] ha [16];
    logic [7:0] hb [16];
    logic [7:0] hc [16];
    int         nh;

    // A debounced bit flips when the newest DEB scans all disagree with it.
    function automatic logic [7:0] deb_rule(input logic [7:0] h [16], input int n,
                                            input logic [7:0] cur);
        logic [7:0] r;
        bit all_diff;
        r = cur;
        if (n >= DEB) begin
            for (int b = 0; b < 8; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (h[k][b] == cur[b]) all_diff = 1'b0;
                if (all_diff) r[b] = ~cur[b];
            end
        end
        return r;
    endfunction
`endif

    always @(posedge CLK) begin
        if (!RESET_N) begin
            e = 0;
            jj_d1 = '1; jj_d2 = '1; jc_d1 = '1; jc_d2 = '1;
            mra = '1; mrb = '1; mrc = '1;
            mdeb_a = '1; mdeb_b = '1; mdeb_c = '1;
            m_jsel = 1'b0; m_done = 1'b0;
            m_joy1 = '1; m_joy2 = '1; m_coin = '1;
`ifdef JOY_DEBOUNCE_EN
            nh = 0;
`endif
        end else begin
            sj = jj_d2; sc = jc_d2;
            jj_d2 = jj_d1; jj_d1 = JJOY;
            jc_d2 = jc_d1; jc_d1 = JCOIN;
            e++;
            if (e > 1 && e % (2*S) == 1) begin
`ifdef JOY_DEBOUNCE_EN
                for (int k = 15; k > 0; k--) begin
                    ha[k] = ha[k-1]; hb[k] = hb[k-1]; hc[k] = hc[k-1];
                end
                ha[0] = mra; hb[0] = mrb; hc[0] = {6'h3F, mrc};
                nh++;
                mdeb_a = deb_rule(ha, nh, mdeb_a);
                mdeb_b = deb_rule(hb, nh, mdeb_b);
                mdeb_c = deb_rule(hc, nh, mdeb_c);
`else
                mdeb_a = mra; mdeb_b = mrb; mdeb_c = {6'h3F, mrc};
`endif
                m_joy1 = {mdeb_a[7:6], mdeb_a[5:0] & KBD_JOY};
                m_joy2 = mdeb_b;
                m_coin = mdeb_c[1:0];
            end
            if (e % S == 0) begin
                if ((e / S) % 2 == 1) mra = sj;
                else begin
                    mrb = sj; mrc = sc;
                end
            end
            m_jsel = ((e / S) % 2) == 1;
            m_done = (e % (2*S)) == 0;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("jselect", {7'b0, JSELECT}, {7'b0, m_jsel});
            check("scan_done", {7'b0, SCAN_DONE}, {7'b0, m_done});
            check("joy1", JOY1, m_joy1);
            check("joy2", JOY2, m_joy2);
            check("coin", {6'b0, COIN}, {6'b0, m_coin});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(input int n);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            do begin
                @(posedge CLK); #1; k++;
            end while (!SCAN_DONE && k < 64);
            check("scan_done_seen", {7'b0, SCAN_DONE}, 8'd1);
            @(posedge CLK); #1;
        end
    endtask

    task automatic first_done(input string name);
        int k = 0;
        do begin
            @(posedge CLK); #1; k++;
        end while (!SCAN_DONE && k < 40);
        check(name, 8'(k + 1), 8'd17);
        @(posedge CLK); #1;
    endtask

    initial begin
        RESET_N = 1'b0; p1 = 8'hFF; p2 = 8'hFF; JCOIN = 2'b11; KBD_JOY = 6'h3F;
        @(posedge CLK); chk_en = 1'b1;
        repeat (4) @(posedge CLK);
        @(negedge CLK); RESET_N = 1'b1;
        check("rst_joy1", JOY1, 8'hFF);
        check("rst_joy2", JOY2, 8'hFF);
        check("rst_coin", {6'b0, COIN}, 8'h03);
        check("rst_jsel", {7'b0, JSELECT}, 8'h00);
        check("rst_done", {7'b0, SCAN_DONE}, 8'h00);
        first_done("first_done_cycle");

        // player mux
        @(negedge CLK); p1 = 8'hFE; p2 = 8'hFD;
        wait_done(3);
        check("mux_joy1", JOY1, 8'hFE);
        check("mux_joy2", JOY2, 8'hFD);

        // single-scan glitch on player 2 bit 4
        @(negedge CLK); p1 = 8'hFF; p2 = 8'hFF;
        wait_done(3);
        @(negedge CLK); p2 = 8'hEF;
        wait_done(1);
        @(negedge CLK); p2 = 8'hFF;
`ifdef JOY_DEBOUNCE_EN
        check("glitch_joy2", JOY2, 8'hFF);
`else
        check("glitch_joy2", JOY2, 8'hEF);
`endif
        wait_done(1);
        check("glitch_gone", JOY2, 8'hFF);
        @(negedge CLK); p2 = 8'hEF;
        wait_done(2);
`ifdef JOY_DEBOUNCE_EN
        check("hold2_joy2", JOY2, 8'hFF);
`else
        check("hold2_joy2", JOY2, 8'hEF);
`endif
        wait_done(1);
        check("hold3_joy2", JOY2, 8'hEF);
        @(negedge CLK); p2 = 8'hFF;
        wait_done(3);

        // keyboard merge
        @(negedge CLK); KBD_JOY = 6'h3B;
        wait_done(1);
        check("kbd_joy1", JOY1, 8'hFB);
        check("kbd_joy2", JOY2, 8'hFF);
        @(negedge CLK); KBD_JOY = 6'h3F;

        // coin
        @(negedge CLK); JCOIN = 2'b10;
        wait_done(4);
        check("coin_on", {6'b0, COIN}, 8'h02);
        @(negedge CLK); JCOIN = 2'b11;
        wait_done(3);
        check("coin_off", {6'b0, COIN}, 8'h03);

        // reset in the middle of SEL_B
        @(negedge CLK); p1 = 8'hF0; p2 = 8'h0F; JCOIN = 2'b01;
        wait_done(3);
        check("pre_joy1", JOY1, 8'hF0);
        repeat (12) @(posedge CLK);
        #1 check("pre_rst_jsel", {7'b0, JSELECT}, 8'h01);
        @(negedge CLK); RESET_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("midrst_no_done", {7'b0, SCAN_DONE}, 8'h00);
        end
        check("midrst_joy1", JOY1, 8'hFF);
        check("midrst_joy2", JOY2, 8'hFF);
        check("midrst_coin", {6'b0, COIN}, 8'h03);
        check("midrst_jsel", {7'b0, JSELECT}, 8'h00);
        @(negedge CLK); RESET_N = 1'b1;
        first_done("restart_done_cycle");
        wait_done(1);

        @(negedge CLK);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jamma_joy_scan.md
JAMMA_JOY_SCAN -- requirements
Module: jamma_joy_scan

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8: clocks JSELECT is held per phase before sampling; legal range 4..255.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 3: consecutive identical scans needed to change a debounced bit; legal range 1..15.
REQ-003 SHALL have port CLK, input, 1: single clock, pixel clock domain.
REQ-004 SHALL have port RESET_N, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port JJOY, input, 8: shared JAMMA joystick bus, active-low, asynchronous.
REQ-006 SHALL have port JCOIN, input, 2: coin switches, active-low, asynchronous.
REQ-007 SHALL have port KBD_JOY, input, 6: keyboard joystick, active-low, synchronous to CLK.
REQ-008 SHALL have port JSELECT, output, 1: player mux select; 0 selects player 1, 1 selects player 2.
REQ-009 SHALL have port JOY1, output, 8: player 1 controls, active-low, as {start, fire2, fire1/up/down/left/right...}, bits[5:0] merged with KBD_JOY.
REQ-010 SHALL have port JOY2, output, 8: player 2 controls, active-low.
REQ-011 SHALL have port COIN, output, 2: conditioned coin switches, active-low.
REQ-012 SHALL have port SCAN_DONE, output, 1: one-cycle pulse after each complete A+B scan.

Function
REQ-013 SHALL pass JJOY and JCOIN through 2-flop synchronizers, giving 2 cycles of latency.
REQ-014 SHALL run an FSM with states SEL_A and SEL_B; SEL_A drives JSELECT=0 and SEL_B drives JSELECT=1, registered.
REQ-015 SHALL hold each state for exactly SETTLE_CYCLES clocks, using a phase counter that runs from 0 to SETTLE_CYCLES-1 and then wraps to 0 on the state change.
REQ-016 SHALL capture synchronized JJOY into raw_a on the SEL_A cycle where the counter equals SETTLE_CYCLES-1, and into raw_b on the same SEL_B cycle.
REQ-017 SHALL capture synchronized JCOIN into raw_coin at the same point as raw_b.
REQ-018 SHALL transition SEL_A to SEL_B, SEL_B to SEL_A, with no other states; the scan period is 2*SETTLE_CYCLES clocks.
REQ-019 SHALL assert SCAN_DONE for one cycle, on the cycle after the raw_b capture.
REQ-020 SHALL update JOY1, JOY2 and COIN only on the SCAN_DONE cycle.
REQ-021 SHALL compute JOY1 = {deb_a[7:6], deb_a[5:0] & KBD_JOY}, so that an active-low press on either source wins.
REQ-022 SHALL use KBD_JOY as the value registered on the SCAN_DONE cycle; KBD_JOY is not debounced.
REQ-023 SHALL let a bit held across a scan-boundary change take the new value only per REQ-026/027; there is no glitch output between scans.

Reset
REQ-024 SHALL, while RESET_N=0 at a CLK edge, force: state SEL_A, counter 0, JSELECT 0, JOY1 8'hFF, JOY2 8'hFF, COIN 2'b11, SCAN_DONE 0, raw and debounced registers all 1s, and debounce counters 0.
REQ-025 SHALL, when reset is asserted mid-scan, abandon the scan without a SCAN_DONE pulse; the first SCAN_DONE arrives 2*SETTLE_CYCLES+1 clocks after RESET_N rises.

Configuration
REQ-026 SHALL, with JOY_DEBOUNCE_EN defined, change each debounced bit only after the raw value differs from it on DEBOUNCE_SCANS consecutive scans; the per-bit counter clears on any agreeing scan and saturates.
REQ-027 SHALL, without JOY_DEBOUNCE_EN, set debounced bits equal to the raw captures of the current scan (one-scan latency), with no debounce counters instantiated.

Structure
REQ-028 SHALL place the FSM state enum (SEL_A, SEL_B), the bit-index constants (JOY_START=7, JOY_FIRE2=6) and the idle constant 8'hFF in shared package joy_pkg.
REQ-029 SHALL use one sub-module, joy_debounce: per-bit scan-tick debouncer, width parameterised, instantiated for 8-bit A, 8-bit B and 2-bit coin.

Verification
REQ-030 SHALL verify reset: hold RESET_N=0 for 5 clocks, then release -> JOY1=JOY2=8'hFF, COIN=2'b11, JSELECT=0, and the first SCAN_DONE at clock 17 (SETTLE_CYCLES=8).
REQ-031 SHALL verify mux timing: drive JJOY=8'hFE when JSELECT=0 and 8'hFD when JSELECT=1 -> JSELECT toggles every 8 clocks, and after 3 scans JOY1=8'hFE, JOY2=8'hFD.
REQ-032 SHALL verify debounce with the macro defined: a 1-scan low glitch on JJOY[4] for player 2 -> JOY2 stays 8'hFF; holding it low for 3 scans -> JOY2=8'hEF at the third SCAN_DONE.
REQ-033 SHALL verify keyboard merge: KBD_JOY=6'h3B with JJOY idle -> JOY1=8'hFB after the next SCAN_DONE; JOY2 is unaffected.
REQ-034 SHALL verify coin: JCOIN=2'b10 for 4 scans -> COIN=2'b10; release -> COIN=2'b11 after 3 scans.
REQ-035 SHALL verify reset mid-scan: RESET_N=0 at counter 5 of SEL_B -> no SCAN_DONE, outputs return to reset values, and scanning restarts in SEL_A.
